// File: rtl/rotary_pkg.sv
// Shared types and defaults for the rotary value controller.
package rotary_pkg;

  typedef enum logic [1:0] {IDLE, INC, DEC, COOL} rot_state_t;

  typedef logic [1:0] step_idx_t;

  localparam int STEP0_DEF = 1;
  localparam int STEP1_DEF = 10;
  localparam int STEP2_DEF = 100;

  function automatic step_idx_t next_step_idx(input step_idx_t cur);
    return (cur == 2'd2) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/rot_sync_edge.sv
// Multi-flop synchroniser with a registered falling-edge pulse and synchronised level.
module rot_sync_edge #(
  parameter int SYNC_STAGES = 3
) (
  input  logic Fg_clk,
  input  logic Resetn,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Stage 0 samples the pin; the edge is taken between the two oldest stages.
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      sync_q <= '0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fall   <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rotary_value_ctrl.sv
// Quadrature detent decoder driving a bounded value with selectable step,
// published to the DDS path once per update period.
module rotary_value_ctrl
  import rotary_pkg::*;
#(
  parameter int CNT_W       = 11,
  parameter int MAX_VAL     = 1799,
  parameter int SYNC_STAGES = 3,
  parameter int COOL_CYC    = 256,
  parameter int DET_TIMEOUT = 65535,
  parameter int DEB_CYC     = 240000,
  parameter int UPD_PERIOD  = 2400000,
  parameter int STEP0       = STEP0_DEF,
  parameter int STEP1       = STEP1_DEF,
  parameter int STEP2       = STEP2_DEF,
  parameter int WRAP        = 0
) (
  input  logic             Fg_clk,
  input  logic             Resetn,
  input  logic             Rot_A,
  input  logic             Rot_B,
  input  logic             Rot_C,
  input  logic [CNT_W-1:0] Min_val,
  output logic [CNT_W-1:0] address,
  output logic             FreqChng,
  output logic [1:0]       step_sel
);

  localparam int TMO_W  = $clog2(DET_TIMEOUT + 1);
  localparam int COOL_W = $clog2(COOL_CYC + 1);
  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int PER_W  = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;

  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(DET_TIMEOUT);
  localparam logic [COOL_W-1:0] COOL_MAX = COOL_W'(COOL_CYC);
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(UPD_PERIOD - 1);
  localparam logic [CNT_W:0]    MAX_EXT  = (CNT_W+1)'(MAX_VAL);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_VAL);

  logic a_lvl, a_fall, b_lvl, b_fall, c_lvl, c_fall_unused;

  rot_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .din(Rot_A), .level(a_lvl), .fall(a_fall));
  rot_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .din(Rot_B), .level(b_lvl), .fall(b_fall));
  rot_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_c (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .din(Rot_C), .level(c_lvl), .fall(c_fall_unused));

  rot_state_t        state;
  logic [CNT_W-1:0]  count;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [COOL_W-1:0] cool_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_lvl;
  logic [PER_W-1:0]  per_cnt;

  logic [CNT_W:0]    step_ext;
  logic [CNT_W:0]    sum_ext;
  logic [CNT_W+1:0]  dec_lim;
  logic [CNT_W-1:0]  inc_val;
  logic [CNT_W-1:0]  dec_val;

  always_comb begin
    step_ext = (CNT_W+1)'(STEP0);
    case (step_sel)
      2'd1:    step_ext = (CNT_W+1)'(STEP1);
      2'd2:    step_ext = (CNT_W+1)'(STEP2);
      default: step_ext = (CNT_W+1)'(STEP0);
    endcase
  end

  // Widened compares so neither direction can alias modulo 2^CNT_W.
  always_comb begin
    sum_ext = {1'b0, count} + step_ext;
    dec_lim = {1'b0, step_ext} + {2'b00, Min_val};
    inc_val = sum_ext[CNT_W-1:0];
    if (sum_ext > MAX_EXT)
      inc_val = (WRAP != 0) ? Min_val : MAX_CNT;
    dec_val = count - step_ext[CNT_W-1:0];
    if ({2'b00, count} < dec_lim)
      dec_val = (WRAP != 0) ? MAX_CNT : Min_val;
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      deb_cnt  <= '0;
      deb_lvl  <= 1'b0;
      step_sel <= 2'd0;
    end else if (c_lvl == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb_cnt <= '0;
      deb_lvl <= c_lvl;
      if (c_lvl)
        step_sel <= next_step_idx(step_sel);
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  // The floor check comes last so it overrides any FSM write to count.
  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      count    <= '0;
      tmo_cnt  <= '0;
      cool_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (b_fall && !a_fall)
            state <= INC;
          else if (a_fall && !b_fall)
            state <= DEC;
        end
        INC: begin
          if (a_fall) begin
            count <= inc_val;
            state <= COOL;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        DEC: begin
          if (b_fall) begin
            count <= dec_val;
            state <= COOL;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        COOL: begin
          if (cool_cnt >= COOL_MAX && a_lvl && b_lvl) begin
            cool_cnt <= '0;
            state    <= IDLE;
          end else if (cool_cnt < COOL_MAX) begin
            cool_cnt <= cool_cnt + COOL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      if (count < Min_val)
        count <= Min_val;
    end
  end

  always_ff @(posedge Fg_clk or negedge Resetn) begin
    if (!Resetn) begin
      per_cnt  <= '0;
      address  <= '0;
      FreqChng <= 1'b0;
    end else begin
      FreqChng <= 1'b0;
      if (per_cnt == PER_LAST) begin
        per_cnt  <= '0;
        address  <= count;
        FreqChng <= (address != count);
      end else begin
        per_cnt <= per_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Directed bench for rotary_value_ctrl: a clamp instance and a wrap instance share stimulus.
module tb_rotary_value_ctrl;
  import rotary_pkg::*;

  localparam int UPD = 100;

  typedef enum {OP_CW, OP_CCW, OP_PRESS, OP_BOUNCE, OP_RESET} op_t;

  typedef struct {
    op_t         op;
    int          reps;
    int          hold;
    logic [10:0] min;
    logic [10:0] exp0;
    logic [10:0] exp1;
    logic [1:0]  exp_step;
  } vec_t;

  logic        Fg_clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        Rot_A  = 1'b1;
  logic        Rot_B  = 1'b1;
  logic        Rot_C  = 1'b0;
  logic [10:0] Min_val = 11'd0;
  logic [10:0] address0, address1;
  logic        fchg0, fchg1;
  logic [1:0]  step0, step1;

  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs[19];

  always #5 Fg_clk = ~Fg_clk;

  rotary_value_ctrl #(
    .UPD_PERIOD(UPD), .COOL_CYC(8), .DEB_CYC(4), .DET_TIMEOUT(50), .WRAP(0)
  ) dut0 (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .Rot_A(Rot_A), .Rot_B(Rot_B), .Rot_C(Rot_C),
    .Min_val(Min_val), .address(address0), .FreqChng(fchg0), .step_sel(step0)
  );

  rotary_value_ctrl #(
    .UPD_PERIOD(UPD), .COOL_CYC(8), .DEB_CYC(4), .DET_TIMEOUT(50), .WRAP(1)
  ) dut1 (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .Rot_A(Rot_A), .Rot_B(Rot_B), .Rot_C(Rot_C),
    .Min_val(Min_val), .address(address1), .FreqChng(fchg1), .step_sel(step1)
  );

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Fg_clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cwDetent();
    Rot_B = 1'b0; waitCycles(6);
    Rot_A = 1'b0; waitCycles(6);
    Rot_A = 1'b1; Rot_B = 1'b1; waitCycles(20);
  endtask

  task automatic ccwDetent();
    Rot_A = 1'b0; waitCycles(6);
    Rot_B = 1'b0; waitCycles(6);
    Rot_A = 1'b1; Rot_B = 1'b1; waitCycles(20);
  endtask

  task automatic pressButton(input int hold);
    Rot_C = 1'b1; waitCycles(hold);
    Rot_C = 1'b0; waitCycles(20);
  endtask

  task automatic applyStimulus(input vec_t v);
    Min_val = v.min;
    for (int r = 0; r < v.reps; r++) begin
      case (v.op)
        OP_CW:     cwDetent();
        OP_CCW:    ccwDetent();
        OP_PRESS:  pressButton(v.hold);
        OP_BOUNCE: begin Rot_C = 1'b1; waitCycles(2); Rot_C = 1'b0; waitCycles(20); end
        OP_RESET:  begin Resetn = 1'b0; waitCycles(2); Resetn = 1'b1; waitCycles(5); end
        default:   waitCycles(1);
      endcase
    end
    waitCycles(UPD + 10);
  endtask

  task automatic runRows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d_addr_clamp", i), 32'(address0), 32'(vecs[i].exp0));
      checkOutput($sformatf("row%0d_addr_wrap", i), 32'(address1), 32'(vecs[i].exp1));
      checkOutput($sformatf("row%0d_step_clamp", i), 32'(step0), 32'(vecs[i].exp_step));
      checkOutput($sformatf("row%0d_step_wrap", i), 32'(step1), 32'(vecs[i].exp_step));
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    int pulses;

    // Rows 0..11 start from count 3 at step index 0 after the first three detents.
    vecs[0]  = '{OP_PRESS,  1, 200, 11'd0,   11'd3,    11'd3,    2'd1};
    vecs[1]  = '{OP_BOUNCE, 1, 0,   11'd0,   11'd3,    11'd3,    2'd1};
    vecs[2]  = '{OP_PRESS,  2, 20,  11'd0,   11'd3,    11'd3,    2'd0};
    vecs[3]  = '{OP_PRESS,  2, 20,  11'd0,   11'd3,    11'd3,    2'd2};
    vecs[4]  = '{OP_CW,     17, 0,  11'd0,   11'd1703, 11'd1703, 2'd2};
    vecs[5]  = '{OP_PRESS,  1, 20,  11'd0,   11'd1703, 11'd1703, 2'd0};
    vecs[6]  = '{OP_PRESS,  1, 20,  11'd0,   11'd1703, 11'd1703, 2'd1};
    vecs[7]  = '{OP_CW,     9, 0,   11'd0,   11'd1793, 11'd1793, 2'd1};
    vecs[8]  = '{OP_PRESS,  2, 20,  11'd0,   11'd1793, 11'd1793, 2'd0};
    vecs[9]  = '{OP_CW,     2, 0,   11'd0,   11'd1795, 11'd1795, 2'd0};
    vecs[10] = '{OP_PRESS,  1, 20,  11'd0,   11'd1795, 11'd1795, 2'd1};
    vecs[11] = '{OP_CW,     1, 0,   11'd0,   11'd1799, 11'd0,    2'd1};
    vecs[12] = '{OP_CW,     3, 0,   11'd0,   11'd3,    11'd3,    2'd0};
    vecs[13] = '{OP_PRESS,  2, 20,  11'd800, 11'd800,  11'd800,  2'd2};
    vecs[14] = '{OP_CCW,    1, 0,   11'd800, 11'd800,  11'd1799, 2'd2};
    vecs[15] = '{OP_RESET,  1, 0,   11'd0,   11'd0,    11'd0,    2'd0};
    vecs[16] = '{OP_CW,     5, 0,   11'd0,   11'd5,    11'd5,    2'd0};
    vecs[17] = '{OP_PRESS,  1, 20,  11'd0,   11'd5,    11'd5,    2'd1};
    vecs[18] = '{OP_CCW,    1, 0,   11'd0,   11'd0,    11'd1799, 2'd1};

    waitCycles(3);
    checkOutput("reset_addr", 32'(address0), 32'd0);
    checkOutput("reset_fchg", 32'(fchg0), 32'd0);
    checkOutput("reset_step", 32'(step0), 32'd0);
    checkOutput("reset_state", 32'(dut0.state), 32'(IDLE));
    Resetn = 1'b1;

    // Start just after the first (silent) tick so all three detents land before the next one.
    waitCycles(101);
    for (int i = 0; i < 3; i++) cwDetent();
    found = 1'b0;
    for (int i = 0; i < 150 && !found; i++) begin
      @(negedge Fg_clk);
      if (fchg0) found = 1'b1;
    end
    checkOutput("cw3_pulse_seen", 32'(found), 32'd1);
    if (found) begin
      checkOutput("cw3_addr_at_pulse", 32'(address0), 32'd3);
      checkOutput("cw3_wrap_pulse", 32'(fchg1), 32'd1);
      @(negedge Fg_clk);
      checkOutput("cw3_pulse_one_cycle", 32'(fchg0), 32'd0);
    end
    pulses = 0;
    for (int i = 0; i < UPD + 10; i++) begin
      @(negedge Fg_clk);
      if (fchg0) pulses++;
    end
    checkOutput("unchanged_no_pulse", 32'(pulses), 32'd0);

    runRows(0, 11);

    // Reset while cooling down with an unpublished update pending.
    Rot_B = 1'b0; waitCycles(6);
    Rot_A = 1'b0; waitCycles(6);
    checkOutput("mid_cool_state", 32'(dut0.state), 32'(COOL));
    Resetn = 1'b0;
    #1;
    checkOutput("rst_cool_addr", 32'(address0), 32'd0);
    checkOutput("rst_cool_fchg", 32'(fchg0), 32'd0);
    checkOutput("rst_cool_step", 32'(step0), 32'd0);
    checkOutput("rst_cool_state", 32'(dut0.state), 32'(IDLE));
    checkOutput("rst_pending_count", 32'(dut1.count), 32'd0);
    Rot_A = 1'b1; Rot_B = 1'b1;
    waitCycles(3);
    Resetn = 1'b1;
    waitCycles(10);

    runRows(12, 12);

    Min_val = 11'd800;
    waitCycles(1);
    checkOutput("floor_clamp_count", 32'(dut0.count), 32'd800);
    checkOutput("floor_wrap_count", 32'(dut1.count), 32'd800);

    runRows(13, 18);

    // Half detent: B falls, A stays high, so INC must time out.
    Rot_B = 1'b0; waitCycles(10);
    checkOutput("tmo_in_inc", 32'(dut0.state), 32'(INC));
    waitCycles(60);
    checkOutput("tmo_back_idle", 32'(dut0.state), 32'(IDLE));
    Rot_A = 1'b0; waitCycles(6);
    Rot_A = 1'b1; Rot_B = 1'b1; waitCycles(80);
    checkOutput("tmo_dec_idle", 32'(dut0.state), 32'(IDLE));
    waitCycles(UPD + 10);
    checkOutput("tmo_addr_clamp", 32'(address0), 32'd0);
    checkOutput("tmo_addr_wrap", 32'(address1), 32'd1799);

    Rot_A = 1'b0; Rot_B = 1'b0; waitCycles(8);
    checkOutput("glitch_idle", 32'(dut0.state), 32'(IDLE));
    Rot_A = 1'b1; Rot_B = 1'b1; waitCycles(10);
    cwDetent();
    waitCycles(UPD + 10);
    checkOutput("post_glitch_clamp", 32'(address0), 32'd10);
    checkOutput("post_glitch_wrap", 32'(address1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
